// File: rtl/modiff_if.sv
// Sample/result bus of the modiff YIN difference engine.
// The master drives the flattened sample window; the slave (modiff) returns ready and d'(tau).
interface modiff_if #(
  parameter int WINDOW_SIZE_BITS        = 8,
  parameter int DATA_WIDTH              = 8,
  parameter int MAX_TAU                 = 40,
  parameter int INTERMEDIATE_DATA_WIDTH = 64
);
  localparam int W = 1 << WINDOW_SIZE_BITS;

  logic [(W+MAX_TAU)*DATA_WIDTH-1:0]  data;
  logic                               ready;
  logic [INTERMEDIATE_DATA_WIDTH-1:0] results [MAX_TAU];

  modport master (output data, input ready, input results);
  modport slave  (input data, output ready, output results);
endinterface

// File: rtl/modiff.sv
// YIN cumulative-mean-normalized difference engine: d(tau) per lag, then d'(tau) via a bit-serial divider.
// Define MODIFF_RAW_DIFF_EN to skip normalization and emit raw d(tau) (results[0] = 0).
module modiff #(
  parameter int WINDOW_SIZE_BITS        = 8,
  parameter int DATA_WIDTH              = 8,
  parameter int MAX_TAU                 = 40,
  parameter int INTERMEDIATE_DATA_WIDTH = 64,
  parameter int FRAC_BITS               = 16
) (
  input  logic    clk,
  input  logic    reset,
  modiff_if.slave bus
);
  localparam int W     = 1 << WINDOW_SIZE_BITS;
  localparam int NS    = W + MAX_TAU;
  localparam int IDW   = INTERMEDIATE_DATA_WIDTH;
  localparam int TAU_W = (MAX_TAU > 1) ? $clog2(MAX_TAU) : 1;
  localparam int IDX_W = $clog2(NS);
  localparam int SQ_W  = 2 * DATA_WIDTH;

  localparam logic [TAU_W-1:0]            TAU_ONE  = TAU_W'(1);
  localparam logic [TAU_W-1:0]            TAU_LAST = TAU_W'(MAX_TAU - 1);
  localparam logic [WINDOW_SIZE_BITS-1:0] J_ONE    = WINDOW_SIZE_BITS'(1);
  localparam logic [WINDOW_SIZE_BITS-1:0] J_LAST   = WINDOW_SIZE_BITS'(W - 1);

  typedef enum logic [2:0] {S_IDLE, S_DIFF, S_NORM, S_DIV, S_DONE} state_e;

  state_e                      state_q;
  logic [TAU_W-1:0]            tau_q;
  logic [WINDOW_SIZE_BITS-1:0] j_q;
  logic [IDW-1:0]              acc_q;
  logic                        ready_q;
  logic [IDW-1:0]              res_q [MAX_TAU];
  logic                        last_tau;

  logic [DATA_WIDTH-1:0] sample [NS];
  for (genvar i = 0; i < NS; i++) begin : g_unpack
    assign sample[i] = bus.data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  logic [IDX_W-1:0]          idx_lag;
  logic signed [DATA_WIDTH:0] diff;
  logic [DATA_WIDTH-1:0]     diff_abs;
  logic [SQ_W-1:0]           sq;

  // NOTE: combinational logic uses blocking assignments; registered state below uses non-blocking only.
  always_comb begin
    idx_lag  = IDX_W'(j_q) + IDX_W'(tau_q);
    diff     = $signed({1'b0, sample[IDX_W'(j_q)]}) - $signed({1'b0, sample[idx_lag]});
    diff_abs = diff[DATA_WIDTH] ? DATA_WIDTH'(-diff) : diff[DATA_WIDTH-1:0];
    sq       = SQ_W'(diff_abs) * SQ_W'(diff_abs);
  end

  assign last_tau = (tau_q == TAU_LAST);

`ifndef MODIFF_RAW_DIFF_EN
  localparam int             DW2      = 2 * IDW;
  localparam int             CNT_W    = $clog2(IDW);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDW - 1);
  localparam logic [IDW-1:0] ONE      = IDW'(1) << FRAC_BITS;

  logic [IDW-1:0]   s_q, rem_q, lo_q, quo_q;
  logic             zero_q, sat_q;
  logic [CNT_W-1:0] cnt_q;

  logic [IDW-1:0] d_cur, s_sum, quo_nxt;
  logic [DW2-1:0] dividend;
  logic [IDW:0]   rem_shift;
  logic           rem_ge;

  // 2N/N restoring divide: remainder starts at the dividend's upper half, lower half shifts in.
  always_comb begin
    d_cur     = res_q[tau_q];
    s_sum     = s_q + d_cur;
    dividend  = (DW2'(d_cur) * DW2'(tau_q)) << FRAC_BITS;
    rem_shift = {rem_q, lo_q[IDW-1]};
    rem_ge    = (rem_shift >= {1'b0, s_q});
    quo_nxt   = {quo_q[IDW-2:0], rem_ge};
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      tau_q   <= '0;
      j_q     <= '0;
      acc_q   <= '0;
      ready_q <= 1'b0;
      // NOTE: the result array doubles as d(tau) scratch storage, so it is cleared like any other state.
      for (int t = 0; t < MAX_TAU; t++) res_q[t] <= '0;
`ifndef MODIFF_RAW_DIFF_EN
      s_q    <= '0;
      rem_q  <= '0;
      lo_q   <= '0;
      quo_q  <= '0;
      zero_q <= 1'b0;
      sat_q  <= 1'b0;
      cnt_q  <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          tau_q   <= TAU_ONE;
          j_q     <= '0;
          acc_q   <= '0;
          state_q <= (MAX_TAU > 1) ? S_DIFF : S_DONE;
        end
        S_DIFF: begin
          j_q <= j_q + J_ONE;
          if (j_q == J_LAST) begin
            res_q[tau_q] <= acc_q + IDW'(sq);
            acc_q        <= '0;
            if (last_tau) begin
              tau_q <= TAU_ONE;
`ifdef MODIFF_RAW_DIFF_EN
              state_q <= S_DONE;
`else
              state_q <= S_NORM;
`endif
            end else begin
              tau_q <= tau_q + TAU_ONE;
            end
          end else begin
            acc_q <= acc_q + IDW'(sq);
          end
        end
`ifndef MODIFF_RAW_DIFF_EN
        S_NORM: begin
          s_q     <= s_sum;
          rem_q   <= dividend[DW2-1:IDW];
          lo_q    <= dividend[IDW-1:0];
          zero_q  <= (s_sum == '0);
          sat_q   <= (dividend[DW2-1:IDW] >= s_sum);
          quo_q   <= '0;
          cnt_q   <= '0;
          state_q <= S_DIV;
        end
        S_DIV: begin
          rem_q <= rem_ge ? IDW'(rem_shift - {1'b0, s_q}) : rem_shift[IDW-1:0];
          lo_q  <= {lo_q[IDW-2:0], 1'b0};
          quo_q <= quo_nxt;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            res_q[tau_q] <= zero_q ? ONE : (sat_q ? '1 : quo_nxt);
            if (last_tau) begin
              state_q <= S_DONE;
            end else begin
              tau_q   <= tau_q + TAU_ONE;
              state_q <= S_NORM;
            end
          end
        end
`endif
        S_DONE: begin
          ready_q <= 1'b1;
`ifdef MODIFF_RAW_DIFF_EN
          res_q[0] <= '0;
`else
          res_q[0] <= ONE;
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.ready = ready_q;
  for (genvar t = 0; t < MAX_TAU; t++) begin : g_res
    assign bus.results[t] = res_q[t];
  end
endmodule

// File: tb/tb_modiff.sv
// Self-checking bench for modiff: a small-window instance with table and random vectors,
// and a default-parameter instance for constant, sine, mid-run reset and hold scenarios.
module tb_modiff;
  localparam int IDW  = 64;
  localparam int S_WB = 2;
  localparam int S_T  = 3;
  localparam int S_W  = 1 << S_WB;
  localparam int D_WB = 8;
  localparam int D_T  = 40;
  localparam int D_W  = 1 << D_WB;
  localparam longint unsigned ONE = 64'd65536;

`ifdef MODIFF_RAW_DIFF_EN
  localparam int S_LAT = 2 + (S_T - 1) * S_W;
  localparam int D_LAT = 2 + (D_T - 1) * D_W;
`else
  localparam int S_LAT = 2 + (S_T - 1) * (S_W + IDW + 1);
  localparam int D_LAT = 2 + (D_T - 1) * (D_W + IDW + 1);
`endif

  logic clk = 1'b0;
  logic reset_s = 1'b1;
  logic reset_d = 1'b1;
  always #5 clk = ~clk;

  modiff_if #(.WINDOW_SIZE_BITS(S_WB), .DATA_WIDTH(8), .MAX_TAU(S_T), .INTERMEDIATE_DATA_WIDTH(IDW)) bus_s ();
  modiff_if #(.WINDOW_SIZE_BITS(D_WB), .DATA_WIDTH(8), .MAX_TAU(D_T), .INTERMEDIATE_DATA_WIDTH(IDW)) bus_d ();

  modiff #(.WINDOW_SIZE_BITS(S_WB), .DATA_WIDTH(8), .MAX_TAU(S_T),
           .INTERMEDIATE_DATA_WIDTH(IDW), .FRAC_BITS(16))
    dut_s (.clk(clk), .reset(reset_s), .bus(bus_s));
  modiff #(.WINDOW_SIZE_BITS(D_WB), .DATA_WIDTH(8), .MAX_TAU(D_T),
           .INTERMEDIATE_DATA_WIDTH(IDW), .FRAC_BITS(16))
    dut_d (.clk(clk), .reset(reset_d), .bus(bus_d));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: d(tau) from the window sum, then running S and fixed-point ratio.
  function automatic void model(input int w, input int t, input int unsigned x[$],
                                output longint unsigned r[$]);
    longint unsigned d [$];
    longint unsigned s;
    r = {};
    d = {};
    for (int tau = 0; tau < t; tau++) begin
      longint unsigned acc;
      acc = 0;
      if (tau > 0)
        for (int j = 0; j < w; j++) begin
          int df;
          df  = int'(x[j]) - int'(x[j+tau]);
          acc += longint'(df * df);
        end
      d.push_back(acc);
    end
    s = 0;
    for (int tau = 0; tau < t; tau++) begin
`ifdef MODIFF_RAW_DIFF_EN
      r.push_back(d[tau]);
`else
      if (tau == 0) r.push_back(ONE);
      else begin
        s += d[tau];
        if (s == 0) r.push_back(ONE);
        else        r.push_back((longint'(tau) * d[tau] * 64'd65536) / s);
      end
`endif
    end
  endfunction

  task automatic load_s(input int unsigned x[$]);
    for (int i = 0; i < x.size(); i++) bus_s.data[i*8 +: 8] = 8'(x[i]);
  endtask

  task automatic load_d(input int unsigned x[$]);
    for (int i = 0; i < x.size(); i++) bus_d.data[i*8 +: 8] = 8'(x[i]);
  endtask

  task automatic run_s(output int lat);
    reset_s = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_s = 1'b0;
    lat = -1;
    for (int n = 1; n <= S_LAT + 50; n++) begin
      @(posedge clk); #1;
      if (bus_s.ready) begin lat = n; break; end
    end
  endtask

  task automatic wait_d(output int lat);
    lat = -1;
    for (int n = 1; n <= D_LAT + 200; n++) begin
      @(posedge clk); #1;
      if (bus_d.ready) begin lat = n; break; end
    end
  endtask

  task automatic start_d();
    reset_d = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_d = 1'b0;
  endtask

  task automatic cmp_d(input string tag, input longint unsigned exp[$]);
    for (int k = 0; k < D_T; k++) check($sformatf("%s_r%0d", tag, k), bus_d.results[k], exp[k]);
  endtask

  typedef struct {
    string           name;
    logic [6:0][7:0] x;
    logic [2:0][63:0] exp_norm;
    logic [2:0][63:0] exp_raw;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int lat;
    int unsigned xs [$];
    int unsigned xd [$];
    int unsigned xsine [$];
    longint unsigned exp [$];
    longint unsigned exp_sine [$];
    logic [2:0][63:0] ev;

    vecs[0].name = "ramp";
    vecs[0].x = {8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
    vecs[0].exp_norm = {64'd104857, 64'd65536, 64'd65536};
    vecs[0].exp_raw  = {64'd16, 64'd4, 64'd0};
    vecs[1].name = "alt";
    vecs[1].x = {8'd0, 8'd10, 8'd0, 8'd10, 8'd0, 8'd10, 8'd0};
    vecs[1].exp_norm = {64'd0, 64'd65536, 64'd65536};
    vecs[1].exp_raw  = {64'd0, 64'd400, 64'd0};
    vecs[2].name = "zero";
    vecs[2].x = '0;
    vecs[2].exp_norm = {64'd65536, 64'd65536, 64'd65536};
    vecs[2].exp_raw  = {64'd0, 64'd0, 64'd0};
    vecs[3].name = "step";
    vecs[3].x = {8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    vecs[3].exp_norm = {64'd131072, 64'd65536, 64'd65536};
    vecs[3].exp_raw  = {64'd65025, 64'd0, 64'd0};
    vecs[4].name = "spike";
    vecs[4].x = {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd255};
    vecs[4].exp_norm = {64'd65536, 64'd65536, 64'd65536};
    vecs[4].exp_raw  = {64'd65025, 64'd65025, 64'd0};

    bus_s.data = '0;
    bus_d.data = '0;
    repeat (2) @(posedge clk); #1;
    check("reset_ready_s", bus_s.ready, 0);
    check("reset_ready_d", bus_d.ready, 0);
    for (int k = 0; k < S_T; k++) check($sformatf("reset_r%0d", k), bus_s.results[k], 0);

    for (int v = 0; v < 5; v++) begin
      bus_s.data = vecs[v].x;
`ifdef MODIFF_RAW_DIFF_EN
      ev = vecs[v].exp_raw;
`else
      ev = vecs[v].exp_norm;
`endif
      run_s(lat);
      check({vecs[v].name, "_lat"}, longint'(lat), S_LAT);
      for (int k = 0; k < S_T; k++)
        check($sformatf("%s_r%0d", vecs[v].name, k), bus_s.results[k], ev[k]);
    end

    for (int r = 0; r < 20; r++) begin
      xs = {};
      for (int i = 0; i < S_W + S_T; i++)
        case ($urandom_range(3))
          0:       xs.push_back(0);
          1:       xs.push_back(255);
          default: xs.push_back($urandom_range(255));
        endcase
      load_s(xs);
      model(S_W, S_T, xs, exp);
      run_s(lat);
      check($sformatf("rnd%0d_lat", r), longint'(lat), S_LAT);
      for (int k = 0; k < S_T; k++) check($sformatf("rnd%0d_r%0d", r, k), bus_s.results[k], exp[k]);
    end

    // Constant input: every d(tau) is zero.
    xd = {};
    for (int i = 0; i < D_W + D_T; i++) xd.push_back(128);
    load_d(xd);
    start_d();
    wait_d(lat);
    check("const_lat", longint'(lat), D_LAT);
    for (int k = 0; k < D_T; k++) begin
`ifdef MODIFF_RAW_DIFF_EN
      check($sformatf("const_r%0d", k), bus_d.results[k], 0);
`else
      check($sformatf("const_r%0d", k), bus_d.results[k], ONE);
`endif
    end

    xsine = {};
    for (int i = 0; i < D_W + D_T; i++) begin
      real ph;
      int  sv;
      ph = 2.0 * 3.14159265358979 * 105.26 * real'(i) / 2000.0;
      sv = int'(127.5 + 127.5 * $sin(ph));
      if (sv > 255) sv = 255;
      if (sv < 0) sv = 0;
      xsine.push_back(int'(sv));
    end
    load_d(xsine);
    model(D_W, D_T, xsine, exp_sine);
    start_d();
    wait_d(lat);
    check("sine_lat", longint'(lat), D_LAT);
    cmp_d("sine", exp_sine);
`ifndef MODIFF_RAW_DIFF_EN
    begin
      int best;
      longint unsigned bv;
      best = 2;
      bv = bus_d.results[2];
      for (int k = 3; k < D_T; k++)
        if (bus_d.results[k] < bv) begin bv = bus_d.results[k]; best = k; end
      check("sine_min_near_19", longint'((best >= 18 && best <= 20) ? 1 : 0), 1);
      check("sine_min_below_0p2", longint'((bv < 64'd13107) ? 1 : 0), 1);
    end
`endif

    begin
      int bad;
      bad = 0;
      for (int c = 0; c < 2000; c++) begin
        @(posedge clk); #1;
        if (bus_d.ready !== 1'b1) bad++;
        for (int k = 0; k < D_T; k++) if (bus_d.results[k] !== exp_sine[k]) bad++;
      end
      check("hold_stable", longint'(bad), 0);
    end

    // Reset midway through DIFF, then a full rerun on the same window.
    start_d();
    repeat ((D_T - 1) * D_W / 2) @(posedge clk);
    @(negedge clk);
    reset_d = 1'b1;
    @(posedge clk); #1;
    check("mid_reset_ready", bus_d.ready, 0);
    begin
      int nz;
      nz = 0;
      for (int k = 0; k < D_T; k++) if (bus_d.results[k] !== 64'd0) nz++;
      check("mid_reset_clear", longint'(nz), 0);
    end
    @(negedge clk);
    reset_d = 1'b0;
    wait_d(lat);
    check("rerun_lat", longint'(lat), D_LAT);
    cmp_d("rerun", exp_sine);

    xd = {};
    for (int i = 0; i < D_W + D_T; i++) xd.push_back($urandom_range(255));
    load_d(xd);
    model(D_W, D_T, xd, exp);
    start_d();
    wait_d(lat);
    check("rndd_lat", longint'(lat), D_LAT);
    cmp_d("rndd", exp);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/modiff.md
# modiff

Cumulative-mean-normalized difference engine (YIN d′(τ)) for the pitch-detection pipeline. Reads a flattened window of W = 2^WINDOW_SIZE_BITS samples plus MAX_TAU look-ahead samples, computes the squared-difference function d(τ) for every lag, and normalizes it to d′(τ) in unsigned fixed point. The downstream threshold/minimum-search stage reads the d′ array once `ready` is high.

## Interface
- WINDOW_SIZE_BITS, 8: W = 2^WINDOW_SIZE_BITS samples summed per lag.
- DATA_WIDTH, 8: unsigned sample width.
- MAX_TAU, 40: number of lags computed, τ = 0..MAX_TAU-1.
- INTERMEDIATE_DATA_WIDTH, 64: accumulator, divider and result width.
- FRAC_BITS, 16: fractional bits of d′; 1.0 = 1<<FRAC_BITS.
- Constraint: 2·DATA_WIDTH + 2 + WINDOW_SIZE_BITS + clog2(MAX_TAU) + FRAC_BITS ≤ INTERMEDIATE_DATA_WIDTH.
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high; also the start trigger.
- ready  out  1  high when all results are final.
- data  in  (W+MAX_TAU)·DATA_WIDTH  sample i at bits [(i+1)·DATA_WIDTH-1 -: DATA_WIDTH]; sample 0 in LSBs.
- results  out  unpacked array [MAX_TAU] × INTERMEDIATE_DATA_WIDTH  d′(τ) per lag (SystemVerilog array port).

## Operation
- One computation per reset release; to recompute, pulse `reset`. `data` must stay stable from reset release until `ready`; it is not latched.
- d(τ) = Σ_{j=0}^{W-1} (x[j] − x[j+τ])², difference signed DATA_WIDTH+1 bits, square unsigned, zero-extended into the accumulator.
- d′(0) = 1<<FRAC_BITS.
- For τ ≥ 1: S(τ) = Σ_{k=1}^{τ} d(k); d′(τ) = floor((τ·d(τ)) << FRAC_BITS / S(τ)).
- S(τ) = 0 → d′(τ) = 1<<FRAC_BITS.
- Quotient exceeding INTERMEDIATE_DATA_WIDTH saturates to all ones (unreachable under the width constraint; still required).
- States:
  - IDLE: held while `reset` high.
  - DIFF: τ = 1..MAX_TAU-1, j = 0..W-1, one squared term per cycle. After j = W-1, raw d(τ) goes to results[τ], then τ++.
  - NORM: τ = 1..MAX_TAU-1. One cycle adds d(τ) to S and loads the divider.
  - DIV: restoring bit-serial divider, INTERMEDIATE_DATA_WIDTH cycles, overwrites results[τ], returns to NORM or advances.
  - DONE: writes results[0], asserts `ready`, holds until reset.
- Raw d(τ) values in the results array serve as storage. results[] is meaningful only while `ready` = 1.

## Timing
- While `reset` = 1: ready = 0, every results[τ] = 0, state IDLE, counters and S cleared.
- First rising edge with `reset` = 0: IDLE → DIFF, τ = 1, j = 0.
- DIFF duration: (MAX_TAU−1)·W cycles.
- NORM+DIV duration: (MAX_TAU−1)·(INTERMEDIATE_DATA_WIDTH+1) cycles.
- `ready` rises exactly 1 + (MAX_TAU−1)·(W + INTERMEDIATE_DATA_WIDTH + 1) + 1 cycles after reset deasserts. `results` do not change while `ready` = 1.
- Reset asserted mid-operation: next edge returns to IDLE, clears ready and results, and discards partial sums.
- MAX_TAU = 1: DIFF and NORM are skipped, so DONE is reached on the second cycle.

## Configuration
- MODIFF_RAW_DIFF_EN defined: NORM/DIV and the divider are not built. DIFF → DONE, and results[τ] = raw d(τ) with results[0] = 0. `ready` rises 2 + (MAX_TAU−1)·W cycles after reset release.
- Undefined: normalized d′ output as above.

## Test plan
- Ramp, WINDOW_SIZE_BITS=2, MAX_TAU=3, FRAC_BITS=16, data 0..6 → results {65536, 65536, 104857}; `ready` at the computed cycle.
- Constant input 128, default params → every results[τ] = 65536 (S = 0 rule).
- Default params, sine 105.26 Hz at fs = 2000, 8-bit offset (0–255), 296 samples → `ready` rises once. Global minimum of results[2..39] is at τ = 19 (±1), below 0.2·65536.
- Reset pulsed halfway through DIFF → `ready` and results drop to 0 on the next edge. After release, the full latency is repeated and results match the uninterrupted run.
- MODIFF_RAW_DIFF_EN with the ramp case → results {0, 4, 16}, `ready` after 2 + 2·4 = 10 cycles.
- Hold `reset` low for 2000 cycles after `ready` → `ready` and results remain constant.
